// File: rtl/aes128_pipe_leak.sv
// aes128_pipe_leak: fully pipelined AES-128 encryptor with an optional
// leakage-emulation channel used as a hardware-trust test target.
//   clk         rising-edge clock
//   rst         asynchronous active-low reset; clears every register
//   state       128-bit plaintext, [127:120] = byte 0, column-major
//   key         128-bit cipher key, same byte order
//   out         ciphertext, 11 register stages after capture
//   Capacitance 64-bit leakage register (constant 0 unless LEAK_CHANNEL_EN)
// Build macro: LEAK_CHANNEL_EN enables the trigger FSM, LFSR and payload.

// S-box: GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes128_pipe_leak (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic [63:0]  Capacitance
);
  localparam int unsigned NR = 10;
  localparam logic [79:0] RCON_TAB = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // sub_rot is SubWord(RotWord(w3)); rc is the round constant.
  function automatic logic [127:0] key_next(input logic [127:0] rk,
                                            input logic [31:0]  sub_rot,
                                            input logic [7:0]   rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st_q [0:NR];
  logic [127:0] rk_q [0:NR-1];
  logic [127:0] st_d [1:NR];
  logic [127:0] rk_d [1:NR];

  // One round per stage; the round key is expanded alongside its block.
  for (genvar r = 1; r <= NR; r++) begin : g_round
    logic [127:0] sb;
    logic [31:0]  rot;
    logic [31:0]  ksub;

    assign rot = {rk_q[r-1][23:0], rk_q[r-1][31:24]};

    for (genvar b = 0; b < 16; b++) begin : g_dsb
      aes_sbox u_sb (.a(st_q[r-1][127-8*b -: 8]), .s(sb[127-8*b -: 8]));
    end
    for (genvar b = 0; b < 4; b++) begin : g_ksb
      aes_sbox u_sb (.a(rot[31-8*b -: 8]), .s(ksub[31-8*b -: 8]));
    end

    assign rk_d[r] = key_next(rk_q[r-1], ksub, RCON_TAB[79-8*(r-1) -: 8]);

    if (r == NR) begin : g_last
      assign st_d[r] = shift_rows(sb) ^ rk_d[r];
    end else begin : g_mid
      assign st_d[r] = mix_columns(shift_rows(sb)) ^ rk_d[r];
    end
  end

  // Pipeline registers; stage 0 performs the initial AddRoundKey.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= NR; i++) st_q[i] <= '0;
      for (int unsigned i = 0; i < NR; i++)  rk_q[i] <= '0;
    end else begin
      st_q[0] <= state ^ key;
      rk_q[0] <= key;
      for (int unsigned i = 1; i <= NR; i++) st_q[i] <= st_d[i];
      for (int unsigned i = 1; i < NR; i++)  rk_q[i] <= rk_d[i];
    end
  end

  assign out = st_q[NR];

`ifdef LEAK_CHANNEL_EN
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S2    = 3'd2;
  localparam logic [2:0] S3    = 3'd3;
  localparam logic [2:0] ARMED = 3'd4;

  localparam logic [127:0] T0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T2 = 128'h0;
  localparam logic [127:0] T3 = {128{1'b1}};

  logic [2:0]   fsm_q, fsm_d;
  logic [63:0]  lfsr_q;
  logic [6:0]   k_q;
  logic [127:0] key_latched_q;
  logic [63:0]  cap_q;
  logic         is_t0;
  logic         lfsr_fb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_q <= IDLE;
    else      fsm_q <= fsm_d;
  end

  // Trigger sequence; a mismatch restarts at S1 if the input is T0.
  always_comb begin
    fsm_d = fsm_q;
    is_t0 = (state == T0);
    case (fsm_q)
      IDLE:    fsm_d = is_t0 ? S1 : IDLE;
      S1:      fsm_d = (state == T1) ? S2 : (is_t0 ? S1 : IDLE);
      S2:      fsm_d = (state == T2) ? S3 : (is_t0 ? S1 : IDLE);
      S3:      fsm_d = (state == T3) ? ARMED : (is_t0 ? S1 : IDLE);
      ARMED:   fsm_d = ARMED;
      default: fsm_d = IDLE;
    endcase
  end

  assign lfsr_fb = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];

  // LFSR is seeded on arming so its all-zero reset value never locks it up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q        <= '0;
      k_q           <= '0;
      key_latched_q <= '0;
      cap_q         <= '0;
    end else if (fsm_q == ARMED) begin
      lfsr_q <= {lfsr_q[62:0], lfsr_fb};
      k_q    <= k_q + 7'd1;
      cap_q  <= lfsr_q ^ {63'd0, key_latched_q[7'd127 - k_q]};
    end else begin
      cap_q <= '0;
      if (fsm_d == ARMED) begin
        key_latched_q <= key;
        lfsr_q        <= 64'h1;
      end
    end
  end

  assign Capacitance = cap_q;
`else
  assign Capacitance = '0;
`endif
endmodule

// File: tb/tb_aes128_pipe_leak.sv
// tb_aes128_pipe_leak: directed self-checking bench for aes128_pipe_leak.
// Expected Capacitance depends on whether LEAK_CHANNEL_EN is defined.
module tb_aes128_pipe_leak;
  localparam logic [127:0] T0     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T1     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T3     = {128{1'b1}};
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_F   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic [63:0]  Capacitance;

  int n_checks = 0;
  int n_fail   = 0;

  aes128_pipe_leak dut (
    .clk(clk), .rst(rst), .state(state), .key(key),
    .out(out), .Capacitance(Capacitance)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // j-th armed output: LFSR from seed 1 is a walking one for these j, XOR key bit 127-j.
  function automatic logic [63:0] cap_exp(input int j);
`ifdef LEAK_CHANNEL_EN
    logic [127:0] kl;
    kl = K_SEQ;
    return (64'd1 << j) ^ {63'd0, kl[127-j]};
`else
    return (j < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  initial begin
    // Reset held with live inputs: everything stays zero.
    rst = 1'b0; state = T0; key = K_FIPS;
    repeat (3) tick();
    chk128("reset_out", out, 128'h0);
    chk64("reset_cap", Capacitance, 64'h0);
    rst = 1'b1;

    // All-zero key and plaintext.
    state = '0; key = '0;
    repeat (11) tick();
    chk128("zero_vec", out, CT_Z);
    repeat (4) tick();
    chk128("zero_vec_hold", out, CT_Z);

    // Appendix C vector, single block, latency boundary.
    state = T1; key = K_SEQ;
    tick();
    state = '0; key = '0;
    repeat (9) tick();
    chk128("lat_minus1", out, CT_Z);
    tick();
    chk128("lat_exact", out, CT_C);
    tick();
    chk128("lat_plus1", out, CT_Z);

    // Back-to-back streaming.
    state = T0; key = K_FIPS;
    tick();
    state = '0; key = '0;
    repeat (10) tick();
    chk128("stream_0", out, CT_F);
    tick();
    chk128("stream_1", out, CT_Z);

    // Broken sequence T0,T1,5,T3 must not arm.
    key = K_SEQ;
    state = T0;          tick();
    state = T1;          tick();
    state = 128'h5;      tick();
    state = T3;          tick();
    state = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk64("broken_seq_cap", Capacitance, 64'h0);
    end

    // T0,T0,T1,T2,T3 arms; nothing leaks before the cycle after ARMED.
    state = T0; tick(); chk64("arm_seq_cap0", Capacitance, 64'h0);
    state = T0; tick(); chk64("arm_seq_cap1", Capacitance, 64'h0);
    state = T1; tick(); chk64("arm_seq_cap2", Capacitance, 64'h0);
    state = '0; tick(); chk64("arm_seq_cap3", Capacitance, 64'h0);
    state = T3; tick(); chk64("arm_seq_cap4", Capacitance, 64'h0);
    state = '0;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk64("armed_cap", Capacitance, cap_exp(j));
      if (j == 7) chk128("armed_cipher", out, CT_C);
    end

    // Asynchronous reset mid-stream clears without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk128("async_rst_out", out, 128'h0);
    chk64("async_rst_cap", Capacitance, 64'h0);
    tick();
    tick();
    chk128("rst_hold_out", out, 128'h0);
    chk64("rst_hold_cap", Capacitance, 64'h0);
    rst = 1'b1;

    // Partial sequence after reset does not re-arm.
    state = T1;  tick();
    state = '0;  tick();
    state = T3;  tick();
    state = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk64("rearm_partial_cap", Capacitance, 64'h0);
    end

    // Full sequence re-arms.
    state = T0; tick();
    state = T1; tick();
    state = '0; tick();
    state = T3; tick();
    state = '0;
    tick();
    chk64("rearm_cap0", Capacitance, cap_exp(0));
    tick();
    chk64("rearm_cap1", Capacitance, cap_exp(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
